// File: rtl/clk_gate_ctrl.sv
// Clock-gate controller: wake with settle delay, idle-timeout shutdown.
// Define GATE_STATS_EN to build the gated-cycle and wake statistics.
module clk_gate_ctrl #(
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        busy,
  output logic        gate_en,
  output logic        ready,
  output logic [1:0]  state,
  output logic [15:0] gated_cycles,
  output logic [7:0]  wake_count
);

  localparam logic [1:0] OFF   = 2'd0;
  localparam logic [1:0] WAKE  = 2'd1;
  localparam logic [1:0] ON    = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic             act;
  logic [CNT_W-1:0] idle_ctr;
  logic [CNT_W-1:0] wake_ctr;

  assign act = req | busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= OFF;
      gate_en  <= 1'b0;
      ready    <= 1'b0;
      idle_ctr <= '0;
      wake_ctr <= '0;
    end else begin
      unique case (state)
        OFF: begin
          if (act) begin
            state    <= WAKE;
            gate_en  <= 1'b1;
            wake_ctr <= '0;
          end
        end
        WAKE: begin
          if (wake_ctr == WAKE_LAST) begin
            state    <= ON;
            ready    <= 1'b1;
            idle_ctr <= '0;
            wake_ctr <= '0;
          end else begin
            wake_ctr <= wake_ctr + ONE;
          end
        end
        ON: begin
          if (act) begin
            idle_ctr <= '0;
          end else if (idle_ctr == IDLE_LAST) begin
            state    <= DRAIN;
            ready    <= 1'b0;
            idle_ctr <= '0;
          end else begin
            idle_ctr <= idle_ctr + ONE;
          end
        end
        DRAIN: begin
          // clock never stopped, so a late request resumes without settling
          if (act) begin
            state    <= ON;
            ready    <= 1'b1;
            idle_ctr <= '0;
          end else begin
            state   <= OFF;
            gate_en <= 1'b0;
          end
        end
        default: begin
          state   <= OFF;
          gate_en <= 1'b0;
          ready   <= 1'b0;
        end
      endcase
    end
  end

`ifdef GATE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      gated_cycles <= '0;
      wake_count   <= '0;
    end else begin
      if (!gate_en && gated_cycles != 16'hFFFF)
        gated_cycles <= gated_cycles + 16'd1;
      if (state == OFF && act && wake_count != 8'hFF)
        wake_count <= wake_count + 8'd1;
    end
  end
`else
  assign gated_cycles = '0;
  assign wake_count   = '0;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl: directed plan plus random bursts.
// Expected outputs come from a phase/elapsed-time model of the controller.
module tb_clk_gate_ctrl;

  localparam int IDLE_N = 8;
  localparam int WAKE_N = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        busy;
  logic        gate_en;
  logic        ready;
  logic [1:0]  state;
  logic [15:0] gated_cycles;
  logic [7:0]  wake_count;

  clk_gate_ctrl #(
    .IDLE_CYCLES(IDLE_N),
    .WAKE_CYCLES(WAKE_N),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .busy(busy),
    .gate_en(gate_en),
    .ready(ready),
    .state(state),
    .gated_cycles(gated_cycles),
    .wake_count(wake_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ph;
    logic [15:0] gc;
    logic [7:0]  wc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // model: phase 0 off, 1 waking, 2 on, 3 draining
  int ph = 0;
  int woke_for = 0;
  int idle_run = 0;
  int n_gated = 0;
  int n_wakes = 0;

  task automatic model(input bit r, input bit a);
    if (r) begin
      ph = 0; woke_for = 0; idle_run = 0;
      n_gated = 0; n_wakes = 0;
      return;
    end
    if (ph == 0 && n_gated < 65535) n_gated++;
    case (ph)
      0: if (a) begin
        ph = 1; woke_for = 0;
        if (n_wakes < 255) n_wakes++;
      end
      1: begin
        woke_for++;
        if (woke_for == WAKE_N) begin ph = 2; idle_run = 0; end
      end
      2: begin
        idle_run = a ? 0 : idle_run + 1;
        if (idle_run == IDLE_N) ph = 3;
      end
      default: begin
        if (a) begin ph = 2; idle_run = 0; end
        else ph = 0;
      end
    endcase
  endtask

  task automatic step(input bit r, input bit q, input bit b);
    exp_t e;
    reset = r; req = q; busy = b;
    @(posedge clk);
    model(r, q | b);
    e.ph = ph;
`ifdef GATE_STATS_EN
    e.gc = 16'(n_gated);
    e.wc = 8'(n_wakes);
`else
    e.gc = '0;
    e.wc = '0;
`endif
    sb.push_back(e);
    #1;
  endtask

  task automatic chk(input string n, input logic [15:0] got,
                     input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("state", 16'(state), 16'(e.ph));
      chk("gate_en", 16'(gate_en), 16'(e.ph != 0));
      chk("ready", 16'(ready), 16'(e.ph == 2));
      chk("gated_cycles", gated_cycles, e.gc);
      chk("wake_count", 16'(wake_count), 16'(e.wc));
    end
  end

  initial begin
    int left;
    bit act_mode;
    // reset then quiet
    step(1, 0, 0);
    step(1, 0, 0);
    repeat (5) step(0, 0, 0);
    // wake
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    // idle out to drain then off
    repeat (IDLE_N + 2) step(0, 0, 0);
    // wake, idle 7, pulse, idle restart
    step(0, 1, 0);
    repeat (WAKE_N) step(0, 1, 0);
    repeat (IDLE_N - 1) step(0, 0, 0);
    step(0, 1, 0);
    repeat (IDLE_N + 2) step(0, 0, 0);
    // drain rescued by busy
    step(0, 0, 1);
    repeat (WAKE_N) step(0, 0, 0);
    repeat (IDLE_N) step(0, 0, 0);
    step(0, 0, 1);
    repeat (IDLE_N + 2) step(0, 0, 0);
    // reset mid-wake, then a full wake
    step(0, 1, 0);
    step(1, 1, 0);
    step(0, 1, 0);
    repeat (WAKE_N + 1) step(0, 0, 0);
    // random bursts of activity and idleness
    left = 0;
    act_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (left == 0) begin
        act_mode = ~act_mode;
        left = act_mode ? $urandom_range(1, 4)
                        : $urandom_range(0, IDLE_N + 3);
      end
      if (left > 0) left--;
      if ($urandom_range(0, 199) == 0)
        step(1, 0, 0);
      else if (act_mode)
        step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        step(0, 0, 0);
    end
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain queue left %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
